tg_flit_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares one output-buffer injection port among NUM_SRC traffic generators (Bernoulli or FSM variants).
- Sits between the generators' flit outputs and the router-side output buffer.
- Grants one source per cycle and holds the grant for the whole packet, from the first flit to the tail flit.
- Keeps a per-source count of packets injected during the measurement window.

---
 rtl/tg_flit_arbiter.sv | 138 +++++++++++++
 tb/tb_tg_flit_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tg_flit_arbiter.sv
// Packet-atomic round-robin arbiter feeding one output-buffer injection port
// from NUM_SRC traffic generators, with per-source packet counters.
module tg_flit_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FLIT_WIDTH = 36,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          measure,
  input  logic                          obuf_full,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_tail,
  input  logic [NUM_SRC*FLIT_WIDTH-1:0] src_flit,
  output logic [NUM_SRC-1:0]            src_grant,
  output logic                          out_valid,
  output logic [FLIT_WIDTH-1:0]         out_flit,
  output logic                          busy,
  output logic [NUM_SRC*CNT_WIDTH-1:0]  pkt_count
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     w_rr_ptr_nxt;
  logic [IDX_W-1:0]     w_owner_nxt;
  logic [IDX_W-1:0]     w_rr_win;
  logic [IDX_W-1:0]     w_win;
  logic                 w_rr_found;
  logic                 w_gnt;
  logic                 w_tail;
  logic [FLIT_WIDTH-1:0] w_flits [NUM_SRC];
  logic [FLIT_WIDTH-1:0] w_flit;
  logic                 r_out_valid;
  logic [FLIT_WIDTH-1:0] r_out_flit;
  logic                 r_busy;
  logic [CNT_WIDTH-1:0] r_cnt [NUM_SRC];

  // First requester strictly after ptr, wrapping; returns {found, index}.
  function automatic logic [IDX_W:0] rr_search(input logic [NUM_SRC-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (req[idx[IDX_W-1:0]]) res = {1'b1, idx[IDX_W-1:0]};
    end
    return res;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign w_flits[gi] = src_flit[gi*FLIT_WIDTH +: FLIT_WIDTH];
    assign pkt_count[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt[gi];
  end

  always_comb begin
    {w_rr_found, w_rr_win} = rr_search(src_valid, r_rr_ptr);
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    w_win        = r_owner;
    w_gnt        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_win = w_rr_win;
        if (enable && !obuf_full && w_rr_found) begin
          w_gnt = 1'b1;
          if (src_tail[w_rr_win]) begin
            w_rr_ptr_nxt = w_rr_win;
          end else begin
            w_owner_nxt = w_rr_win;
            w_state_nxt = S_LOCKED;
          end
        end
      end
      S_LOCKED: begin
        // Only the owner may advance; a gap from the owner just stalls.
        if (src_valid[r_owner] && !obuf_full) begin
          w_gnt = 1'b1;
          if (src_tail[r_owner]) begin
            w_rr_ptr_nxt = r_owner;
            w_state_nxt  = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_tail    = src_tail[w_win];
    w_flit    = w_flits[w_win];
    src_grant = '0;
    if (w_gnt) src_grant[w_win] = 1'b1;
  end

  // Register stage: arbitration state and output flit
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= IDX_W'(NUM_SRC - 1);
      r_owner     <= '0;
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_out_valid <= w_gnt;
      r_busy      <= (w_state_nxt == S_LOCKED);
      if (w_gnt) r_out_flit <= w_flit;
    end
  end

  for (genvar gc = 0; gc < NUM_SRC; gc++) begin : g_cnt
    always_ff @(posedge clock) begin
      if (reset) begin
        r_cnt[gc] <= '0;
      end else if (w_gnt && w_tail && measure && (w_win == IDX_W'(gc))) begin
        r_cnt[gc] <= sat_inc(r_cnt[gc]);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_flit  = r_out_flit;
  assign busy      = r_busy;

endmodule

// File: tb/tb_tg_flit_arbiter.sv
// Scoreboard bench for tg_flit_arbiter: a packet-level reference model predicts
// grants, busy and counters; a monitor pops expected flits as they emerge.
module tb_tg_flit_arbiter;
  localparam int N   = 4;
  localparam int FW  = 36;
  localparam int CW  = 16;
  localparam int CW2 = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            measure = 1'b0;
  logic            obuf_full = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N-1:0]    src_tail = '0;
  logic [N*FW-1:0] src_flit = '0;

  logic [N-1:0]    src_grant, src_grant2;
  logic            out_valid, out_valid2;
  logic [FW-1:0]   out_flit, out_flit2;
  logic            busy, busy2;
  logic [N*CW-1:0]  pkt_count;
  logic [N*CW2-1:0] pkt_count2;

  tg_flit_arbiter #(.NUM_SRC(N), .FLIT_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .measure(measure),
    .obuf_full(obuf_full), .src_valid(src_valid), .src_tail(src_tail),
    .src_flit(src_flit), .src_grant(src_grant), .out_valid(out_valid),
    .out_flit(out_flit), .busy(busy), .pkt_count(pkt_count));

  tg_flit_arbiter #(.NUM_SRC(N), .FLIT_WIDTH(FW), .CNT_WIDTH(CW2)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .measure(measure),
    .obuf_full(obuf_full), .src_valid(src_valid), .src_tail(src_tail),
    .src_flit(src_flit), .src_grant(src_grant2), .out_valid(out_valid2),
    .out_flit(out_flit2), .busy(busy2), .pkt_count(pkt_count2));

  always #5 clock = ~clock;

  typedef struct {
    logic [FW-1:0] flit;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  // Reference model: current packet owner (-1 = none), last served source, counts.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cnt  [N];
  int m_cnt2 [N];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_cnt2[i] = 0;
    end
    q.delete();
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] t,
                      input logic en, input logic ms, input logic full);
    logic [63:0]   r;
    logic [FW-1:0] fl [N];
    logic [N-1:0]  eg;
    int            win;
    int            j;
    src_valid = v;
    src_tail  = t;
    enable    = en;
    measure   = ms;
    obuf_full = full;
    for (int i = 0; i < N; i++) begin
      r = {$urandom, $urandom};
      fl[i] = r[FW-1:0];
      src_flit[i*FW +: FW] = fl[i];
    end
    #1;
    win = -1;
    if (m_owner < 0) begin
      if (en && !full) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (v[j] && win < 0) win = j;
        end
      end
    end else if (v[m_owner] && !full) begin
      win = m_owner;
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    chk("src_grant", src_grant, eg);
    chk("src_grant_sat", src_grant2, eg);
    chk("busy", busy, m_owner >= 0);
    chk("busy_sat", busy2, m_owner >= 0);
    if (win >= 0) begin
      q.push_back('{fl[win], cyc});
      if (t[win]) begin
        m_last  = win;
        m_owner = -1;
        if (ms) begin
          if (m_cnt[win] < (1 << CW) - 1) m_cnt[win]++;
          if (m_cnt2[win] < (1 << CW2) - 1) m_cnt2[win]++;
        end
      end else begin
        m_owner = win;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_flit", out_flit, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt_count", pkt_count, '0);
    chk("rst_pkt_count_sat", pkt_count2, '0);
  endtask

  task automatic check_counts();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("pkt_count[%0d]", i), pkt_count[i*CW +: CW], m_cnt[i]);
      chk($sformatf("pkt_count_sat[%0d]", i), pkt_count2[i*CW2 +: CW2], m_cnt2[i]);
    end
  endtask

  // Monitor: an entry stamped in cycle c must appear on the outputs in cycle c+1.
  always @(negedge clock) begin
    exp_t e;
    bit   exp_v;
    if (mon_en && !reset) begin
      while (q.size() > 0 && q[0].cyc < cyc - 1) void'(q.pop_front());
      exp_v = (q.size() > 0) && (q[0].cyc == cyc - 1);
      chk("out_valid", out_valid, exp_v);
      chk("out_valid_sat", out_valid2, exp_v);
      if (exp_v) begin
        e = q.pop_front();
        chk("out_flit", out_flit, e.flit);
        chk("out_flit_sat", out_flit2, e.flit);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rv, rt;
    model_reset();
    #1;
    do_reset();
    mon_en = 1'b1;

    // Round robin with single-flit packets from every source
    repeat (6) step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);

    // Packet atomicity: src0 three flits while src1 waits
    do_reset();
    step(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(4'b0011, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);

    // Backpressure after the head flit of a src2 packet
    step(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (4) step(4'b0110, 4'b0000, 1'b1, 1'b0, 1'b1);
    step(4'b0110, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(4'b0110, 4'b0100, 1'b1, 1'b0, 1'b0);

    // Owner gap with enable dropped mid-packet
    step(4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (2) step(4'b0111, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 4'b1000, 1'b0, 1'b0, 1'b0);
    repeat (3) step(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);

    // Counting and saturation
    do_reset();
    repeat (5) step(4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0);
    chk("cnt2_measured", pkt_count[2*CW +: CW], 5);
    chk("cnt2_saturated", pkt_count2[2*CW2 +: CW2], 3);
    repeat (3) step(4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);
    chk("cnt2_unmeasured", pkt_count[2*CW +: CW], 5);
    chk("cnt0_idle", pkt_count[0 +: CW], 0);
    check_counts();

    // Reset in the middle of a src1 packet
    step(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0);
    do_reset();
    src_valid = 4'b1111;
    src_tail  = 4'b1111;
    #1;
    chk("first_after_reset", src_grant, 4'b0001);
    step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);

    // Randomised traffic
    repeat (2000) begin
      rv = N'($urandom);
      rt = ($urandom_range(2) == 0) ? N'($urandom) : '0;
      step(rv, rt, ($urandom_range(9) != 0), ($urandom_range(3) != 0),
           ($urandom_range(4) == 0));
    end
    check_counts();

    repeat (2) step('0, '0, 1'b0, 1'b0, 1'b0);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
